cfg_serial_bank_reg: RTL and testbench
======================================

// Module: cfg_serial_bank_reg
// PURPOSE
// - Next-generation serial configuration register: one serial frame (SEL/SDI/SDO) writes or reads back one of
//   NUM_BANKS latched configuration banks, instead of a single fixed static/dynamic chain.
// - Frames are fed by the fsm_ctrl-style serial source; latched banks and the decoded analog-mux one-hot drive the front-end.
// - Adds bank addressing, readback, exact-length checking, error reporting and selectable bit order.
// PARAMETERS
// NUM_BANKS   4   number of latched banks (>=2)
// ADDR_W      2   bank address width, = clog2(NUM_BANKS)
// BANK_W      88  bits per bank (> MUXADDR_W)
// MUXADDR_W   7   AMUXSEL address width; AMUXSEL width = 2**MUXADDR_W
// AMUX_BANK   1   bank whose bits [MUXADDR_W:0] drive AMUXSEL
// MSB_FIRST   1   1: header/payload MSB first on SDI and SDO; 0: LSB first
// PORTS
// CLK      in   1                    system/serial clock, all logic on rising edge
// RST_N    in   1                    reset, asynchronous, active low
// SEL      in   1                    frame enable, high for the whole frame
// SDI      in   1                    serial data in, one bit per CLK with SEL=1
// SDO      out  1                    serial data out (readback), registered
// BANK_Q   out  NUM_BANKS*BANK_W     latched banks, bank b at [b*BANK_W +: BANK_W]
// AMUXSEL  out  2**MUXADDR_W         one-hot analog mux select
// WR_DONE  out  1                    1-cycle pulse: write committed
// FRAME_ERR out 1                    1-cycle pulse: frame rejected
// ERR      out  1                    status of last completed frame (1 = rejected)
// BEHAVIOUR
// - Reset (async, RST_N=0): state IDLE, counter 0, BANK_Q=0, SDO=0, WR_DONE=0, FRAME_ERR=0, ERR=0, AMUXSEL=0.
// - Frame = HDR_W=1+ADDR_W header bits {WR, ADDR} then BANK_W payload bits; one bit per rising edge with SEL=1.
// - FSM: IDLE -(SEL=1: bit 0)-> HDR -(HDR_W bits taken)-> PAYLOAD -(BANK_W bits taken, SEL still 1)-> OVERRUN.
//   Any state -(SEL sampled 0)-> IDLE, with end-of-frame evaluation done on that same edge.
// - Bit counter width clog2(HDR_W+BANK_W+1); it saturates in OVERRUN, never wraps.
// - Payload shifts into a shadow register; BANK_Q changes only on commit.
// - Readback: on the edge taking the last header bit, the addressed bank's latched value loads into the output shifter.
//   SDO shows payload bit 0 (MSB or LSB per MSB_FIRST) in the next cycle and advances one bit per payload edge.
//   Readback runs for both WR=0 and WR=1, so a write returns the old contents.
// - SDO=0 in IDLE, HDR and OVERRUN, and for the whole frame when ADDR>=NUM_BANKS.
// - End of frame (first edge with SEL=0 after >=1 bit):
//   - Commit: WR=1, ADDR<NUM_BANKS, exactly HDR_W+BANK_W bits. Shadow is copied into bank ADDR on this edge.
//     WR_DONE=1 for the following cycle; ERR cleared.
//   - Successful read: WR=0, ADDR valid, exact count. No bank change; ERR cleared; no pulse.
//   - Otherwise (short frame, overrun, bad ADDR): no bank change, FRAME_ERR pulse, ERR set.
//   - A SEL high/low with zero bits sampled is no frame: no pulse, ERR unchanged.
// - SEL re-asserted on the edge right after the ending edge starts a new frame normally (back-to-back allowed).
// - AMUXSEL is registered from the AMUX_BANK latch: bit[MUXADDR_W] is the enable, bits [MUXADDR_W-1:0] the index.
//   enable=0 -> all zero. Updates one cycle after the commit to AMUX_BANK.
// - Reset mid-frame: frame discarded, all banks cleared, no pulses.
// STRUCTURE
// - cfg_reg_pkg: FSM state encoding (IDLE/HDR/PAYLOAD/OVERRUN), HDR_W/WR-bit position localparams, clog2 function.
// - Sub-module onehot_dec #(MUXADDR_W): registered index+enable -> one-hot AMUXSEL.
// - Bit-order handling is a generate on MSB_FIRST around the shadow and readback shifters.
// TESTING
// - Reset then write bank 2 with 88'hA5... (WR=1, ADDR=2'b10, MSB_FIRST) -> BANK_Q bank2 = pattern, others 0.
//   WR_DONE pulses once; ERR=0.
// - Read bank 2 (WR=0, ADDR=2) -> SDO emits the same 88 bits MSB first starting the cycle after the last header bit.
//   BANK_Q unchanged; no WR_DONE.
// - Short frame: 50 of 88 payload bits, then SEL=0 -> FRAME_ERR pulse, ERR=1, banks unchanged.
//   Next valid frame -> ERR=0.
// - Overrun: 95 payload bits -> SDO=0 after bit 88, no commit, FRAME_ERR pulse.
//   Bad address: NUM_BANKS=3, ADDR=3 -> SDO=0 throughout, FRAME_ERR pulse, no commit.
// - Write bank1 with index 7'd37 and enable=1 -> AMUXSEL=1<<37 one cycle after WR_DONE.
//   Rewrite with enable=0 -> AMUXSEL=0.
// - RST_N low at payload bit 40 of a write to bank0 that held a previous value -> all banks 0, no pulses.
//   MSB_FIRST=0 build: LSB-first write then read round-trips identically.

Source files
------------

// File: rtl/cfg_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_reg_pkg
//  Description : Shared types and helpers for the banked serial config register:
//                frame FSM state encoding, header layout, constant clog2.
//  Revision    : 1.0 - initial release
// ============================================================================
package cfg_reg_pkg;

    // Frame FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_OVERRUN = 2'd3
    } state_e;

    // Header is {WR, ADDR}: one write flag above the bank address
    localparam int WR_FLAG_W = 1;

    function automatic int hdr_width(input int addr_w);
        return WR_FLAG_W + addr_w;
    endfunction

    function automatic int wr_bit_pos(input int addr_w);
        return addr_w;
    endfunction

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_dec
//  Description : Registered index+enable to one-hot decoder for the analog mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec #(
    parameter int MUXADDR_W = 7
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      en_i,
    input  logic [MUXADDR_W-1:0]      idx_i,
    output logic [2**MUXADDR_W-1:0]   onehot_o
);

    logic [2**MUXADDR_W-1:0] onehot_q;
    logic [2**MUXADDR_W-1:0] onehot_d;

    // Decode: a disabled selector drives no mux input at all
    always_comb begin
        onehot_d = '0;
        if (en_i) begin
            onehot_d[idx_i] = 1'b1;
        end
    end

    // Output register so the mux select is glitch-free
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            onehot_q <= '0;
        end else begin
            onehot_q <= onehot_d;
        end
    end

    assign onehot_o = onehot_q;

endmodule
`default_nettype wire

// File: rtl/cfg_serial_bank_reg.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_serial_bank_reg
//  Description : Serial (SEL/SDI/SDO) configuration register with NUM_BANKS
//                latched banks, addressed write/readback, exact-length frame
//                checking, error reporting and selectable bit order.
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_serial_bank_reg
    import cfg_reg_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 2,
    parameter int BANK_W    = 88,
    parameter int MUXADDR_W = 7,
    parameter int AMUX_BANK = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          sel_i,
    input  logic                          sdi_i,
    output logic                          sdo_o,
    output logic [NUM_BANKS*BANK_W-1:0]   bank_q_o,
    output logic [2**MUXADDR_W-1:0]       amuxsel_o,
    output logic                          wr_done_o,
    output logic                          frame_err_o,
    output logic                          err_o
);

    localparam int HDR_W     = hdr_width(ADDR_W);
    localparam int WR_POS    = wr_bit_pos(ADDR_W);
    localparam int FRAME_LEN = HDR_W + BANK_W;
    localparam int CNT_W     = clog2(FRAME_LEN + 1);

    localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HDR_W-1:0]    hdr_q, hdr_d;
    logic [BANK_W-1:0]   shadow_q, shadow_d;
    logic [BANK_W-1:0]   rb_q, rb_d, rb_src, rb_src_d;
    logic                rb_first, rb_src_first;
    logic                sdo_q;
    logic                wr_done_q, frame_err_q, err_q;
    logic [BANK_W-1:0]   bank_q [NUM_BANKS];

    logic                take_hdr, hdr_last, take_pay, end_frame;
    logic                w_wr, w_addr_ok, w_exact, w_commit, w_read_ok, w_reject;
    logic [ADDR_W-1:0]   w_addr, w_hdr_addr;

    // Bit-order specific shifting of header, shadow and readback paths
    if (MSB_FIRST != 0) begin : g_msb_first
        assign hdr_d        = {hdr_q[HDR_W-2:0], sdi_i};
        assign shadow_d     = {shadow_q[BANK_W-2:0], sdi_i};
        assign rb_src_first = rb_src[BANK_W-1];
        assign rb_src_d     = {rb_src[BANK_W-2:0], 1'b0};
        assign rb_first     = rb_q[BANK_W-1];
        assign rb_d         = {rb_q[BANK_W-2:0], 1'b0};
    end else begin : g_lsb_first
        assign hdr_d        = {sdi_i, hdr_q[HDR_W-1:1]};
        assign shadow_d     = {sdi_i, shadow_q[BANK_W-1:1]};
        assign rb_src_first = rb_src[0];
        assign rb_src_d     = {1'b0, rb_src[BANK_W-1:1]};
        assign rb_first     = rb_q[0];
        assign rb_d         = {1'b0, rb_q[BANK_W-1:1]};
    end

    // Frame FSM state and bit counter registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, bit accounting and per-edge strobes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        take_hdr  = 1'b0;
        hdr_last  = 1'b0;
        take_pay  = 1'b0;
        end_frame = 1'b0;
        if (state_q != ST_IDLE && !sel_i) begin
            end_frame = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_i) begin
                        take_hdr = 1'b1;
                        cnt_d    = CNT_W'(1);
                        state_d  = ST_HDR;
                    end
                end
                ST_HDR: begin
                    take_hdr = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_HDR_LAST) begin
                        hdr_last = 1'b1;
                        state_d  = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_FRAME) begin
                        state_d = ST_OVERRUN;
                    end else begin
                        take_pay = 1'b1;
                    end
                end
                ST_OVERRUN: begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // End-of-frame evaluation on the completed header
    assign w_wr       = hdr_q[WR_POS];
    assign w_addr     = hdr_q[ADDR_W-1:0];
    assign w_hdr_addr = hdr_d[ADDR_W-1:0];
    assign w_addr_ok  = (int'(w_addr) < NUM_BANKS);
    assign w_exact    = (state_q == ST_PAYLOAD) && (cnt_q == CNT_FRAME);
    assign w_commit   = end_frame && w_wr && w_addr_ok && w_exact;
    assign w_read_ok  = end_frame && !w_wr && w_addr_ok && w_exact;
    assign w_reject   = end_frame && !(w_addr_ok && w_exact);

    // Readback source: an out-of-range address reads as all zeros
    always_comb begin
        rb_src = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_hdr_addr == ADDR_W'(b)) begin
                rb_src = bank_q[b];
            end
        end
    end

    // Header/shadow capture, readback shifter, SDO and status flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hdr_q       <= '0;
            shadow_q    <= '0;
            rb_q        <= '0;
            sdo_q       <= 1'b0;
            wr_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (take_hdr) begin
                hdr_q <= hdr_d;
            end
            if (take_pay) begin
                shadow_q <= shadow_d;
            end
            if (hdr_last) begin
                sdo_q <= rb_src_first;
                rb_q  <= rb_src_d;
            end else if (take_pay) begin
                sdo_q <= rb_first;
                rb_q  <= rb_d;
            end else begin
                sdo_q <= 1'b0;
            end
            wr_done_q   <= w_commit;
            frame_err_q <= w_reject;
            if (w_commit || w_read_ok) begin
                err_q <= 1'b0;
            end else if (w_reject) begin
                err_q <= 1'b1;
            end
        end
    end

    // Latched banks: only a committed write frame changes them
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_commit && (w_addr == ADDR_W'(b))) begin
                    bank_q[b] <= shadow_q;
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank_out
        assign bank_q_o[b*BANK_W +: BANK_W] = bank_q[b];
    end

    onehot_dec #(
        .MUXADDR_W (MUXADDR_W)
    ) u_amux_dec (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (bank_q[AMUX_BANK][MUXADDR_W]),
        .idx_i    (bank_q[AMUX_BANK][MUXADDR_W-1:0]),
        .onehot_o (amuxsel_o)
    );

    assign sdo_o       = sdo_q;
    assign wr_done_o   = wr_done_q;
    assign frame_err_o = frame_err_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_serial_bank_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cfg_serial_bank_reg
//  Description : Self-checking bench: an MSB-first 4-bank instance and an
//                LSB-first 3-bank instance driven from a frame table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_serial_bank_reg;

    localparam int BW = 88;

    localparam logic [BW-1:0] P_A5     = {11{8'hA5}};
    localparam logic [BW-1:0] P_B      = 88'h0123_4567_89AB_CDEF_FEDC_BA;
    localparam logic [BW-1:0] P_C      = ~P_B;
    localparam logic [BW-1:0] P_LSB    = 88'hC3_5A_0F_96_E1_7D_28_B4_44_19_F0;
    localparam logic [BW-1:0] AMUX_ON  = {80'hDEAD_BEEF_0123_4567_89AB, 8'hA5};
    localparam logic [BW-1:0] AMUX_OFF = {80'hDEAD_BEEF_0123_4567_89AB, 8'h25};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel_v [2];
    logic sdi_v [2];
    logic sdo_v [2];
    logic wr_done_v [2];
    logic ferr_v [2];
    logic err_v [2];
    logic [4*BW-1:0] bank0;
    logic [3*BW-1:0] bank1;
    logic [127:0]    amux_v [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit sdo;
        bit wr_done;
        bit frame_err;
    } exp_t;
    exp_t sb[$];

    logic [BW-1:0] model [2][4];

    typedef struct {
        int            d;
        bit            wr;
        logic [1:0]    addr;
        logic [BW-1:0] data;
        int            npay;
        bit            commit;
        bit            err;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;

    cfg_serial_bank_reg #(
        .NUM_BANKS(4), .ADDR_W(2), .BANK_W(BW), .MUXADDR_W(7), .AMUX_BANK(1), .MSB_FIRST(1)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .sel_i(sel_v[0]), .sdi_i(sdi_v[0]), .sdo_o(sdo_v[0]),
        .bank_q_o(bank0), .amuxsel_o(amux_v[0]), .wr_done_o(wr_done_v[0]),
        .frame_err_o(ferr_v[0]), .err_o(err_v[0])
    );

    cfg_serial_bank_reg #(
        .NUM_BANKS(3), .ADDR_W(2), .BANK_W(BW), .MUXADDR_W(7), .AMUX_BANK(1), .MSB_FIRST(0)
    ) dut_lsb (
        .clk_i(clk), .rst_n_i(rst_n), .sel_i(sel_v[1]), .sdi_i(sdi_v[1]), .sdo_o(sdo_v[1]),
        .bank_q_o(bank1), .amuxsel_o(amux_v[1]), .wr_done_o(wr_done_v[1]),
        .frame_err_o(ferr_v[1]), .err_o(err_v[1])
    );

    function automatic int nb(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic bit bit_at(input logic [BW-1:0] v, input int k, input int d);
        return (d == 0) ? v[BW-1-k] : v[k];
    endfunction

    function automatic logic [BW-1:0] dut_bank(input int d, input int a);
        return (d == 0) ? bank0[a*BW +: BW] : bank1[a*BW +: BW];
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_pop(input int d, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk($sformatf("%s sdo", tag), 128'(sdo_v[d]), 128'(e.sdo));
            chk($sformatf("%s wr_done", tag), 128'(wr_done_v[d]), 128'(e.wr_done));
            chk($sformatf("%s frame_err", tag), 128'(ferr_v[d]), 128'(e.frame_err));
        end
    endtask

    task automatic post_check(input int d, input bit exp_err, input string tag);
        logic [BW-1:0]  m;
        logic [127:0]   exp_amux;
        for (int a = 0; a < nb(d); a++) begin
            chk($sformatf("%s bank%0d", tag, a), 128'(dut_bank(d, a)), 128'(model[d][a]));
        end
        chk($sformatf("%s err", tag), 128'(err_v[d]), 128'(exp_err));
        m = model[d][1];
        exp_amux = m[7] ? (128'd1 << m[6:0]) : 128'd0;
        chk($sformatf("%s amuxsel", tag), amux_v[d], exp_amux);
    endtask

    task automatic check_quiet(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d sdo", tag, d), 128'(sdo_v[d]), 128'd0);
            chk($sformatf("%s d%0d wr_done", tag, d), 128'(wr_done_v[d]), 128'd0);
            chk($sformatf("%s d%0d frame_err", tag, d), 128'(ferr_v[d]), 128'd0);
            post_check(d, 1'b0, $sformatf("%s d%0d", tag, d));
        end
    endtask

    // One frame: header {wr,addr} plus npay payload bits, then SEL low.
    // rst_at >= 0 pulls reset low instead of driving bit index rst_at.
    task automatic run_frame(input int d, input bit wr, input logic [1:0] addr,
                             input logic [BW-1:0] data, input int npay, input bit commit,
                             input bit exp_err, input bit idle_after, input int rst_at,
                             input string tag);
        logic [2:0]    hdr;
        logic [BW-1:0] old;
        bit            valid;
        bit            b;
        bit            es;
        int            k;
        hdr   = {wr, addr};
        valid = (int'(addr) < nb(d));
        old   = valid ? model[d][addr] : '0;
        for (int i = 0; i < 3 + npay; i++) begin
            if (i < 3) b = (d == 0) ? hdr[2-i] : hdr[i];
            else       b = bit_at(data, i - 3, d);
            @(negedge clk);
            if (i == rst_at) begin
                rst_n    = 1'b0;
                sel_v[d] = 1'b0;
                sdi_v[d] = 1'b0;
                #1;
                sb.delete();
                for (int dd = 0; dd < 2; dd++)
                    for (int a = 0; a < 4; a++) model[dd][a] = '0;
                check_quiet({tag, " in-reset"});
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            sel_v[d] = 1'b1;
            sdi_v[d] = b;
            k  = (i < 2) ? -1 : i - 2;
            es = (valid && k >= 0 && k < BW) ? bit_at(old, k, d) : 1'b0;
            sb.push_back('{es, 1'b0, 1'b0});
            @(posedge clk);
            #1 check_pop(d, $sformatf("%s bit%0d", tag, i));
        end
        @(negedge clk);
        sel_v[d] = 1'b0;
        sdi_v[d] = 1'b0;
        sb.push_back('{1'b0, commit, exp_err});
        @(posedge clk);
        #1 check_pop(d, {tag, " end"});
        if (commit) model[d][addr] = data;
        if (idle_after) begin
            @(negedge clk);
            sb.push_back('{1'b0, 1'b0, 1'b0});
            @(posedge clk);
            #1 check_pop(d, {tag, " idle"});
            post_check(d, exp_err, tag);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          d  wr addr   data      npay commit err
        tbl[0]  = '{0, 1, 2'd2, P_A5,     88,  1,     0};  // write bank2
        tbl[1]  = '{0, 0, 2'd2, '0,       88,  0,     0};  // read bank2
        tbl[2]  = '{0, 1, 2'd1, P_B,      50,  0,     1};  // short frame
        tbl[3]  = '{0, 0, 2'd0, '0,       88,  0,     0};  // valid read clears ERR
        tbl[4]  = '{0, 1, 2'd2, P_B,      95,  0,     1};  // overrun
        tbl[5]  = '{0, 1, 2'd1, AMUX_ON,  88,  1,     0};  // amux enable, index 37
        tbl[6]  = '{0, 1, 2'd1, AMUX_OFF, 88,  1,     0};  // amux disable
        tbl[7]  = '{1, 1, 2'd3, P_B,      88,  0,     1};  // bad address (3 banks)
        tbl[8]  = '{1, 1, 2'd0, P_LSB,    88,  1,     0};  // LSB-first write
        tbl[9]  = '{1, 0, 2'd0, '0,       88,  0,     0};  // LSB-first readback
        tbl[10] = '{0, 1, 2'd0, P_B,      88,  1,     0};  // preload bank0

        for (int d = 0; d < 2; d++) begin
            sel_v[d] = 1'b0;
            sdi_v[d] = 1'b0;
            for (int a = 0; a < 4; a++) model[d][a] = '0;
        end

        repeat (3) @(negedge clk);
        #1 check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_quiet("post-reset");

        for (int t = 0; t < 11; t++) begin
            run_frame(tbl[t].d, tbl[t].wr, tbl[t].addr, tbl[t].data, tbl[t].npay,
                      tbl[t].commit, tbl[t].err, 1'b1, -1, $sformatf("vec%0d", t));
        end

        // Back-to-back: write bank3 then read it with no idle cycle between
        run_frame(0, 1'b1, 2'd3, P_C, 88, 1'b1, 1'b0, 1'b0, -1, "b2b-wr");
        run_frame(0, 1'b0, 2'd3, '0, 88, 1'b0, 1'b0, 1'b1, -1, "b2b-rd");

        // Reset at payload bit 40 of a write to bank0
        run_frame(0, 1'b1, 2'd0, P_C, 88, 1'b0, 1'b0, 1'b0, 3 + 40, "rstmid");
        repeat (2) begin
            @(negedge clk);
            sb.push_back('{1'b0, 1'b0, 1'b0});
            @(posedge clk);
            #1 check_pop(0, "rstmid after");
        end
        check_quiet("rstmid after");

        // Recovery after reset
        run_frame(0, 1'b1, 2'd0, P_A5, 88, 1'b1, 1'b0, 1'b1, -1, "recover-wr");
        run_frame(1, 1'b0, 2'd0, '0, 88, 1'b0, 1'b0, 1'b1, -1, "recover-rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
